dff_async_pipe: RTL
===================

// Module: dff_async_pipe
// PURPOSE
//  Parametrised multi-bit, multi-stage flip-flop pipeline with async active-low reset.
//  Carries a WIDTH-bit word through DEPTH registered stages with a valid/ready handshake.
//  Adds per-stage stall, a synchronous flush and an occupancy count.
//  Drives true and complement outputs.
//  Used wherever the design needs a registered delay line that back-pressure can stall.
// PARAMETERS
//  WIDTH     8      data bits per word (>=1)
//  DEPTH     3      number of register stages (>=1); unstalled latency in cycles
//  RESET_VAL 0      WIDTH-bit value loaded into every stage data register on reset/flush
// PORTS
//  clk      in   1              rising-edge clock
//  reset    in   1              asynchronous, active-low reset (0 = reset asserted)
//  i_flush  in   1              synchronous clear of all stage valid bits
//  i_valid  in   1              input word present
//  o_ready  out  1              pipeline accepts input this cycle
//  i_d      in   WIDTH          input data
//  o_valid  out  1              last stage holds a word
//  i_ready  in   1              downstream accepts o_q this cycle
//  o_q      out  WIDTH          last-stage data
//  o_qb     out  WIDTH          ~o_q, bitwise
//  o_count  out  $clog2(DEPTH+1) number of valid stages (0..DEPTH)
// BEHAVIOUR
//  - Reset (reset==0, async, no clock needed):
//    - all stage valid bits = 0, all stage data = RESET_VAL
//    - o_valid=0, o_q=RESET_VAL, o_qb=~RESET_VAL, o_count=0
//    - o_ready=1 once reset deasserts
//  - Reset deassertion is taken as synchronous to clk; the first accept is possible
//    on the first rising edge with reset==1.
//  - Stage k (0=input side, DEPTH-1=output) has v[k] and data[k].
//    - Stage k advances when adv[k] = ~v[k] | rdy[k+1], where rdy[DEPTH] = i_ready.
//  - o_ready = adv[0]:
//    - combinational from i_ready through the chain
//    - no combinational path from i_valid or i_d to o_ready
//  - On a clock edge where adv[k]:
//    - v[k] <= v[k-1] (stage 0: i_valid)
//    - data[k] <= data[k-1] (stage 0: i_d), loaded only when the incoming valid is 1
//  - Stalled stage (adv[k]==0): holds v and data unchanged.
//  - Bubbles collapse: a stalled output still lets upstream empty stages fill.
//  - Transfers:
//    - input transfer = i_valid & o_ready
//    - output transfer = o_valid & i_ready
//    - both may occur in one cycle; throughput is 1 word/cycle
//  - Latency: a word accepted at edge N appears on o_q with o_valid=1 after edge N+DEPTH-1.
//    This holds when no stall occurs; it is DEPTH register stages.
//  - o_q/o_qb come directly from the data[DEPTH-1] flops; no logic after the register.
//    o_qb is a separate inverted register, or the inverter of o_q; either way it equals ~o_q at all times.
//  - o_count is registered:
//    - +1 on input transfer only, -1 on output transfer only, unchanged on both or neither
//    - never exceeds DEPTH and never goes below 0
//  - i_flush=1 at an edge:
//    - all v <= 0, data <= RESET_VAL, o_count <= 0
//    - overrides any simultaneous input transfer; the word is dropped
//    - o_ready remains combinational, so upstream may see a handshake that is discarded
//  - Reset asserted mid-stall or mid-transfer: state clears immediately; in-flight words are lost.
//  - Data in invalid stages is don't-care for checking, except after reset or flush (RESET_VAL).
// STRUCTURE
//  - Package dff_async_pkg:
//    - default WIDTH/DEPTH localparams
//    - function clog2_cnt(depth), which returns the o_count width
//  - Sub-module dff_async_stage, instantiated DEPTH times with a generate loop:
//    - one stage: v and data flops with async active-low reset
//    - ports: adv input, flush input, upstream v/data, downstream rdy
//  - Top level holds the ready chain, occupancy counter and output assignment.
// TESTING  (WIDTH=8, DEPTH=3, RESET_VAL=8'h00 unless noted)
//  1. Reset then stream: i_d = 8'hA5, 8'h3C, 8'hFF with i_valid=1 and i_ready=1 held.
//     -> o_q = A5, 3C, FF on consecutive cycles starting 2 edges after the first accept.
//     -> o_qb = 5A, C3, 00.
//  2. Back-pressure: fill 3 words with i_ready=0.
//     -> o_count=3, o_ready=0, o_q held.
//     Then raise i_ready for 1 cycle -> o_count=2, o_ready=1.
//  3. Simultaneous transfer at full:
//     - setup: pipeline full, i_valid=1, i_ready=1
//     - o_count stays 3 and a new word enters the pipeline
//     - output order is preserved
//  4. Flush with i_valid=1 and o_ready=1:
//     -> next cycle o_valid=0, o_count=0, o_q=00.
//     -> The flushed-cycle input word never appears at the output.
//  5. Async reset mid-stream: drive reset=0 between clock edges while 2 words are in flight.
//     -> o_valid=0, o_q=00, o_qb=FF immediately, before the next edge.
//  6. Random 1000 cycles with random i_valid, i_ready and i_d:
//     - a scoreboard FIFO matches the o_q sequence
//     - o_count equals the scoreboard depth, never exceeding 3
//     - check with DEPTH=1, WIDTH=1

Source files
------------

// File: rtl/dff_async_pkg.sv
// Shared defaults and helpers for the stallable register pipeline.
package dff_async_pkg;

  localparam int DEFAULT_WIDTH = 8;
  localparam int DEFAULT_DEPTH = 3;

  // The occupancy count must represent every value from 0 to depth.
  function automatic int clog2_cnt(input int depth);
    return (depth < 1) ? 1 : $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/dff_async_stage.sv
// One pipeline stage: valid and data flops that load from upstream whenever the stage advances.
module dff_async_stage
  import dff_async_pkg::*;
#(
  parameter int               WIDTH     = DEFAULT_WIDTH,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst_ni,
  input  logic             adv_i,
  input  logic             flush_i,
  input  logic             v_i,
  input  logic [WIDTH-1:0] d_i,
  output logic             v_o,
  output logic [WIDTH-1:0] d_o
);

  logic             v_q, v_d;
  logic [WIDTH-1:0] d_q, d_d;

  always_comb begin
    v_d = v_q;
    d_d = d_q;
    if (flush_i) begin
      v_d = 1'b0;
      d_d = RESET_VAL;
    end else if (adv_i) begin
      v_d = v_i;
      // Data only moves with a real word; bubbles leave the previous contents in place.
      if (v_i) begin
        d_d = d_i;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_ni) begin
    if (!rst_ni) begin
      v_q <= 1'b0;
      d_q <= RESET_VAL;
    end else begin
      v_q <= v_d;
      d_q <= d_d;
    end
  end

  assign v_o = v_q;
  assign d_o = d_q;

endmodule

// File: rtl/dff_async_pipe.sv
// Multi-stage valid/ready register pipeline with bubble collapse, flush and occupancy count.
module dff_async_pipe
  import dff_async_pkg::*;
#(
  parameter int               WIDTH     = DEFAULT_WIDTH,
  parameter int               DEPTH     = DEFAULT_DEPTH,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          i_flush,
  input  logic                          i_valid,
  output logic                          o_ready,
  input  logic [WIDTH-1:0]              i_d,
  output logic                          o_valid,
  input  logic                          i_ready,
  output logic [WIDTH-1:0]              o_q,
  output logic [WIDTH-1:0]              o_qb,
  output logic [clog2_cnt(DEPTH)-1:0]   o_count
);

  localparam int CW = clog2_cnt(DEPTH);

  // Index 0 is the upstream input; index k+1 is the output of stage k.
  logic [DEPTH:0]            v_chain;
  logic [DEPTH:0][WIDTH-1:0] d_chain;
  logic [DEPTH-1:0]          adv;
  logic                      in_xfer;
  logic                      out_xfer;
  logic [CW-1:0]             count_q, count_d;

  assign v_chain[0] = i_valid;
  assign d_chain[0] = i_d;

  // A stage advances if it or any stage downstream of it is empty, or the sink is ready.
  always_comb begin
    logic acc;
    acc = i_ready;
    adv = '0;
    for (int k = DEPTH - 1; k >= 0; k--) begin
      acc    = acc | ~v_chain[k+1];
      adv[k] = acc;
    end
  end

  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_stage
    dff_async_stage #(
      .WIDTH     (WIDTH),
      .RESET_VAL (RESET_VAL)
    ) u_stage (
      .clk     (clk),
      .rst_ni  (reset),
      .adv_i   (adv[gi]),
      .flush_i (i_flush),
      .v_i     (v_chain[gi]),
      .d_i     (d_chain[gi]),
      .v_o     (v_chain[gi+1]),
      .d_o     (d_chain[gi+1])
    );
  end

  assign in_xfer  = i_valid & adv[0];
  assign out_xfer = v_chain[DEPTH] & i_ready;

  always_comb begin
    count_d = count_q;
    if (i_flush) begin
      count_d = '0;
    end else if (in_xfer && !out_xfer) begin
      count_d = count_q + CW'(1);
    end else if (out_xfer && !in_xfer) begin
      count_d = count_q - CW'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign o_ready = adv[0];
  assign o_valid = v_chain[DEPTH];
  assign o_q     = d_chain[DEPTH];
  assign o_qb    = ~d_chain[DEPTH];
  assign o_count = count_q;

endmodule
